// File: rtl/nn_layer_pkg.sv
// rtl/nn_layer_pkg.sv - shared types and constants for the layer driver
package nn_layer_pkg;

  localparam int DW       = 8;
  localparam int FRAC     = 4;
  localparam int N_IN_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    RUN,
    CAPTURE,
    ABORT
  } state_t;

  typedef logic signed [DW-1:0] elem_t;
  typedef elem_t sample_t [N_IN_DEF];

endpackage

// File: rtl/nn_sample_fifo.sv
// rtl/nn_sample_fifo.sv - synchronous sample FIFO with registered ready flag
module nn_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         ready,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ready_q;
  logic          do_push, do_pop;

  // A push while full is still taken when the same cycle pops a slot free.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign ready = ready_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/nn_layer_driver.sv
// rtl/nn_layer_driver.sv - buffers samples, sequences one-shot layer runs, captures results
module nn_layer_driver
  import nn_layer_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int DW      = nn_layer_pkg::DW,
  parameter int IDXW    = 1,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N_IN*DW-1:0] s_data,
  output logic               l_rst,
  output logic               l_req,
  input  logic [IDXW-1:0]    l_idx,
  output logic [DW-1:0]      l_x,
  input  logic               l_ack,
  input  logic [DW-1:0]      l_a,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [DW-1:0]      r_data,
  output logic               busy,
  output logic               err
);

  localparam int CW = $clog2(TIMEOUT);

  state_t             state_q, state_d;
  logic [N_IN*DW-1:0] hold_q, fifo_rdata;
  logic [CW-1:0]      cnt_q;
  logic               fifo_empty;
  logic               layer_rst_q;
  logic               at_timeout;

  nn_sample_fifo #(
    .W    (N_IN*DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (s_valid && s_ready),
    .pop  (state_q == LOAD),
    .wdata(s_data),
    .rdata(fifo_rdata),
    .ready(s_ready),
    .empty(fifo_empty)
  );

  assign at_timeout = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty && !r_valid) state_d = LOAD;
      LOAD:    state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN: begin
        if (l_ack)           state_d = CAPTURE;
        else if (at_timeout) state_d = ABORT;
      end
      CAPTURE: state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The layer stays in reset until the first clean cycle after driver reset.
  assign l_rst = layer_rst_q || (state_q == CLEAR) || (state_q == ABORT);
  assign l_req = (state_q == RUN);
  assign busy  = (state_q != IDLE);

  always_comb begin
    l_x = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (l_idx == IDXW'(i)) l_x = hold_q[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cnt_q       <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      err         <= 1'b0;
      layer_rst_q <= 1'b1;
    end else begin
      layer_rst_q <= 1'b0;
      state_q     <= state_d;
      if (state_q == LOAD) hold_q <= fifo_rdata;
      if (state_q == CLEAR)                 cnt_q <= '0;
      else if (state_q == RUN && !at_timeout) cnt_q <= cnt_q + 1'b1;
      // Result is captured on the ack edge so r_valid follows l_ack by one cycle.
      if (state_q == RUN && l_ack) begin
        r_data  <= l_a;
        r_valid <= 1'b1;
      end else if (r_valid && r_ready) begin
        r_valid <= 1'b0;
      end
      if (state_q == ABORT) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nn_layer_driver.sv
// tb/tb_nn_layer_driver.sv - scoreboard bench for nn_layer_driver with a behavioural layer
module tb_nn_layer_driver;

  localparam int N = 2;
  localparam int K = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        l_rst, l_req;
  logic [0:0]  l_idx;
  logic [7:0]  l_x;
  logic        l_ack;
  logic [7:0]  l_a;
  logic        r_valid, r_ready;
  logic [7:0]  r_data;
  logic        busy, err;

  logic        s1_valid, s1_ready, l1_rst, l1_req, l1_ack, r1_valid, r1_ready, busy1, err1;
  logic [7:0]  s1_data, l1_x, l1_a, r1_data;
  logic [0:0]  l1_idx;

  always #5 clk = ~clk;

  nn_layer_driver #(.N_IN(2), .DW(8), .IDXW(1), .DEPTH(4), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .l_rst(l_rst), .l_req(l_req), .l_idx(l_idx), .l_x(l_x), .l_ack(l_ack), .l_a(l_a),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .busy(busy), .err(err)
  );

  nn_layer_driver #(.N_IN(1), .DW(8), .IDXW(1), .DEPTH(4), .TIMEOUT(64)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data),
    .l_rst(l1_rst), .l_req(l1_req), .l_idx(l1_idx), .l_x(l1_x), .l_ack(l1_ack), .l_a(l1_a),
    .r_valid(r1_valid), .r_ready(r1_ready), .r_data(r1_data), .busy(busy1), .err(err1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [15:0] smp_q[$];
  logic [7:0]  exp_q[$];

  // Layer transfer function: a0 = x0 - x1 + 18 (so (16,-8) -> 0x2A).
  function automatic logic [7:0] model_a(input logic [15:0] s);
    return s[7:0] - s[15:8] + 8'd18;
  endfunction

  // Behavioural layer: reads each index once, acks K cycles after l_req.
  bit         ack_m = 0, force_ack = 0, no_ack = 0, prev_req = 0;
  int         rcnt = 0, ack_cyc = -10;
  logic [7:0] xs [N];
  assign l_ack = ack_m || force_ack;

  always @(negedge clk) begin
    logic [15:0] s;
    logic [7:0]  e;
    if (!rst || l_rst) begin
      ack_m = 0;
      rcnt  = 0;
      l_idx = 1'b0;
    end else if (l_req && !ack_m) begin
      if (rcnt < N) begin
        l_idx = 1'(rcnt);
        #1;
        xs[rcnt] = l_x;
        if (smp_q.size() > 0) begin
          s = smp_q[0];
          e = s[rcnt*8 +: 8];
          chk(l_x == e, "l_x", int'(l_x), int'(e));
        end
      end
      rcnt++;
      if (rcnt == K && !no_ack) begin
        ack_m   = 1;
        l_a     = xs[0] - xs[1] + 8'd18;
        ack_cyc = cyc;
      end
    end
    if (prev_req && !l_req && smp_q.size() > 0) void'(smp_q.pop_front());
    prev_req = l_req;
  end

  // Monitor: scoreboard on result handshakes plus protocol observations.
  bit         pv_rv = 0, pv_req = 0, pv_lrst = 1, pv_hs = 0;
  int         rst_pulses = 0, req_len = 0, last_req_len = 0, req_rises = 0;
  logic [7:0] held = '0;

  always begin
    logic [7:0] e;
    @(negedge clk);
    #2;
    if (!rst) begin
      pv_rv = 0; pv_req = 0; pv_lrst = 1; pv_hs = 0;
      rst_pulses = 0; req_len = 0;
    end else begin
      if (l_rst && !pv_lrst) rst_pulses++;
      if (l_req && !pv_req) begin
        req_rises++;
        chk(rst_pulses == 1, "one_lrst_per_req", rst_pulses, 1);
        chk(!r_valid, "no_req_while_rvalid", int'(r_valid), 0);
        req_len = 0;
      end
      if (l_req) req_len++;
      if (!l_req && pv_req) begin
        last_req_len = req_len;
        chk(l_rst == no_ack, "abort_pulse", int'(l_rst), int'(no_ack));
        rst_pulses = 0;
      end
      if (r_valid && !pv_rv) chk(cyc == ack_cyc + 1, "ack_to_rvalid", cyc - ack_cyc, 1);
      if (r_valid && pv_rv && !pv_hs) chk(r_data == held, "r_data_stable", int'(r_data), int'(held));
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) chk(0, "unexpected_result", int'(r_data), -1);
        else begin
          e = exp_q.pop_front();
          chk(r_data == e, "r_data", int'(r_data), int'(e));
        end
      end
      held    = r_data;
      pv_hs   = r_valid && r_ready;
      pv_rv   = r_valid;
      pv_req  = l_req;
      pv_lrst = l_rst;
    end
  end

  task automatic push(input logic [7:0] x0, input logic [7:0] x1, input bit want);
    int n = 0;
    s_data  = {x1, x0};
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk(0, "push_timeout", n, 0);
    @(posedge clk);
    smp_q.push_back({x1, x0});
    if (want) exp_q.push_back(model_a({x1, x0}));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_req(input bit lvl, input int lim);
    int n = 0;
    while (l_req !== lvl && n < lim) begin @(negedge clk); n++; end
    chk(n < lim, "wait_l_req", n, lim);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || r_valid || exp_q.size() != 0) && n < 400) begin @(negedge clk); n++; end
    chk(n < 400, "wait_idle", n, 400);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rises;
    rst = 1'b0; s_valid = 1'b0; s_data = '0; r_ready = 1'b1; l_a = '0;
    s1_valid = 1'b0; s1_data = '0; l1_idx = 1'b0; l1_ack = 1'b0; l1_a = '0; r1_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk(s_ready == 0, "rst_s_ready", int'(s_ready), 0);
    chk(l_rst == 1,   "rst_l_rst",   int'(l_rst), 1);
    chk(l_req == 0,   "rst_l_req",   int'(l_req), 0);
    chk(l_x == 0,     "rst_l_x",     int'(l_x), 0);
    chk(r_valid == 0, "rst_r_valid", int'(r_valid), 0);
    chk(r_data == 0,  "rst_r_data",  int'(r_data), 0);
    chk(busy == 0,    "rst_busy",    int'(busy), 0);
    chk(err == 0,     "rst_err",     int'(err), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single sample (16,-8): l_req 3 cycles after FIFO goes non-empty, result 0x2A.
    push(8'd16, 8'hF8, 1'b1);
    n = 1;
    while (!l_req && n < 20) begin @(negedge clk); n++; end
    chk(n == 4, "req_latency", n, 4);
    wait_idle();

    // Five back-to-back samples fill the FIFO while the first runs.
    push(8'd1, 8'd2, 1'b1);
    push(8'd3, 8'hFC, 1'b1);
    push(8'd100, 8'd50, 1'b1);
    push(8'h80, 8'd1, 1'b1);
    push(8'd7, 8'd7, 1'b1);
    chk(s_ready == 0, "fifo_full_s_ready", int'(s_ready), 0);
    wait_idle();

    // Result backpressure: no new run while r_valid is pending.
    r_ready = 1'b0;
    push(8'd30, 8'd10, 1'b1);
    push(8'd5, 8'd40, 1'b1);
    n = 0;
    while (!r_valid && n < 100) begin @(negedge clk); n++; end
    chk(n < 100, "wait_r_valid", n, 100);
    rises = req_rises;
    repeat (20) @(negedge clk);
    chk(r_valid == 1, "r_valid_held", int'(r_valid), 1);
    chk(req_rises == rises, "no_second_req", req_rises, rises);
    r_ready = 1'b1;
    wait_idle();

    // Layer never acks: 64-cycle run, abort pulse, sticky err.
    no_ack = 1;
    push(8'd5, 8'd6, 1'b0);
    wait_req(1'b1, 20);
    wait_req(1'b0, 200);
    repeat (3) @(negedge clk);
    no_ack = 0;
    chk(last_req_len == 64, "timeout_req_len", last_req_len, 64);
    chk(err == 1, "timeout_err", int'(err), 1);
    chk(r_valid == 0, "timeout_no_result", int'(r_valid), 0);
    push(8'd7, 8'hFD, 1'b1);
    wait_idle();
    chk(err == 1, "err_sticky", int'(err), 1);

    // Ack pulse while idle is ignored.
    l_a = 8'h55;
    force_ack = 1;
    @(negedge clk);
    force_ack = 0;
    repeat (5) @(negedge clk);
    chk(r_valid == 0, "idle_ack_no_result", int'(r_valid), 0);
    chk(busy == 0, "idle_ack_not_busy", int'(busy), 0);

    // Reset in the middle of a run, with a second sample queued.
    push(8'd9, 8'd9, 1'b1);
    push(8'd10, 8'd11, 1'b1);
    wait_req(1'b1, 20);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk(l_req == 0,   "midrst_l_req",   int'(l_req), 0);
    chk(l_rst == 1,   "midrst_l_rst",   int'(l_rst), 1);
    chk(r_valid == 0, "midrst_r_valid", int'(r_valid), 0);
    chk(err == 0,     "midrst_err",     int'(err), 0);
    chk(s_ready == 0, "midrst_s_ready", int'(s_ready), 0);
    smp_q.delete();
    exp_q.delete();
    rst = 1'b1;
    rises = req_rises;
    repeat (10) @(negedge clk);
    chk(req_rises == rises, "fifo_empty_after_rst", req_rises, rises);
    chk(busy == 0, "idle_after_rst", int'(busy), 0);
    push(8'd20, 8'd4, 1'b1);
    wait_idle();

    // Single-input instance: out-of-range index reads as zero.
    s1_data  = 8'h33;
    s1_valid = 1'b1;
    n = 0;
    while (!s1_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    s1_valid = 1'b0;
    n = 0;
    while (!l1_req && n < 20) begin @(negedge clk); n++; end
    chk(n < 20, "n1_wait_req", n, 20);
    l1_idx = 1'b0;
    #1 chk(l1_x == 8'h33, "n1_l_x_idx0", int'(l1_x), 'h33);
    l1_idx = 1'b1;
    #1 chk(l1_x == 8'h00, "n1_l_x_idx1", int'(l1_x), 0);
    l1_a   = 8'h11;
    l1_ack = 1'b1;
    n = 0;
    while (!r1_valid && n < 20) begin @(negedge clk); n++; end
    chk(r1_valid == 1, "n1_r_valid", int'(r1_valid), 1);
    chk(r1_data == 8'h11, "n1_r_data", int'(r1_data), 'h11);
    @(negedge clk);
    l1_ack = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
